// File: rtl/de_pkg.sv
// Decode->Execute payload types shared by the ID/EX stage register and its users.
// Contents: default field widths, control/data/payload packed structs, and a helper
// that clears the commit-capable control bits of an invalid entry.
package de_pkg;

  localparam int unsigned DE_XLEN     = 64;
  localparam int unsigned DE_REG_AW   = 5;
  localparam int unsigned DE_ALUCTL_W = 4;
  localparam int unsigned DE_RESSRC_W = 2;

  typedef struct packed {
    logic                   reg_write;
    logic [DE_RESSRC_W-1:0] result_src;
    logic                   mem_write;
    logic [DE_ALUCTL_W-1:0] alu_control;
    logic                   alu_src;
    logic                   branch;
    logic                   jump;
  } de_ctrl_t;

  typedef struct packed {
    logic [DE_XLEN-1:0]   rd1;
    logic [DE_XLEN-1:0]   rd2;
    logic [DE_XLEN-1:0]   pc;
    logic [DE_XLEN-1:0]   imm_ext;
    logic [DE_REG_AW-1:0] rd;
    logic [DE_REG_AW-1:0] rs1;
    logic [DE_REG_AW-1:0] rs2;
  } de_data_t;

  typedef struct packed {
    de_ctrl_t ctrl;
    de_data_t data;
  } de_payload_t;

  localparam int unsigned DE_PAYLOAD_W = $bits(de_payload_t);

  // An empty or flushed stage must never write the regfile/memory or redirect fetch.
  function automatic de_ctrl_t gate_ctrl(input de_ctrl_t c, input logic valid);
    de_ctrl_t g;
    g           = c;
    g.reg_write = c.reg_write & valid;
    g.mem_write = c.mem_write & valid;
    g.branch    = c.branch & valid;
    g.jump      = c.jump & valid;
    return g;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with synchronous flush and optional skid entry.
// Ports: clk, rst (async active-low), flush, in_valid/in_ready/in_data (upstream),
//        out_valid/out_ready/out_data (downstream).
// SKID=1: main + skid entry, in_ready comes straight from a flop.
// SKID=0: single entry, in_ready = ~out_valid | out_ready (combinational).
module pipe_skid_buf #(
  parameter int unsigned W    = 8,
  parameter bit          SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid, main_valid_n;
  logic         skid_valid, skid_valid_n;
  logic [W-1:0] main_data, main_data_n;
  logic [W-1:0] skid_data, skid_data_n;
  logic         rdy_q, rdy_n;
  logic         accept;
  logic         load_main;

  // Main entry can take new data when it is empty or being consumed this cycle.
  assign load_main = ~main_valid | out_ready;
  assign in_ready  = SKID ? rdy_q : load_main;
  assign accept    = in_valid & in_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Next-state: flush wins, then skid drains into main, then input fills main or skid.
  always_comb begin
    main_valid_n = main_valid;
    main_data_n  = main_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else if (load_main) begin
      if (skid_valid) begin
        main_valid_n = 1'b1;
        main_data_n  = skid_data;
        skid_valid_n = 1'b0;
      end else begin
        main_valid_n = accept;
        if (accept) begin
          main_data_n = in_data;
        end
      end
    end else if (accept && SKID) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end
    rdy_n = ~skid_valid_n;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
      rdy_q      <= 1'b1;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      main_data  <= main_data_n;
      skid_data  <= skid_data_n;
      rdy_q      <= rdy_n;
    end
  end

endmodule

// File: rtl/id_ex_elastic_reg.sv
// Decode->Execute elastic stage register.
// Ports: clk, rst (async active-low), flush, in_valid/in_ready + *_D decode fields,
//        out_valid/out_ready + *_E execute fields, stall_cnt/bubble_cnt perf counters.
// Packs the D fields into de_payload_t, buffers them in pipe_skid_buf, gates the
// commit-capable controls with out_valid and keeps saturating stall/bubble counters.
module id_ex_elastic_reg
  import de_pkg::*;
#(
  parameter int unsigned XLEN     = DE_XLEN,
  parameter int unsigned REG_AW   = DE_REG_AW,
  parameter int unsigned ALUCTL_W = DE_ALUCTL_W,
  parameter int unsigned RESSRC_W = DE_RESSRC_W,
  parameter bit          SKID     = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     RD1_D,
  input  logic [XLEN-1:0]     RD2_D,
  input  logic [XLEN-1:0]     PC_D,
  input  logic [XLEN-1:0]     ImmExt_D,
  input  logic [REG_AW-1:0]   Rd_D,
  input  logic [REG_AW-1:0]   Rs1_D,
  input  logic [REG_AW-1:0]   Rs2_D,
  input  logic                RegWrite_D,
  input  logic [RESSRC_W-1:0] ResultSrc_D,
  input  logic                MemWrite_D,
  input  logic [ALUCTL_W-1:0] ALUControl_D,
  input  logic                ALUSrc_D,
  input  logic                Branch_D,
  input  logic                Jump_D,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     RD1_E,
  output logic [XLEN-1:0]     RD2_E,
  output logic [XLEN-1:0]     PC_E,
  output logic [XLEN-1:0]     ImmExt_E,
  output logic [REG_AW-1:0]   Rd_E,
  output logic [REG_AW-1:0]   Rs1_E,
  output logic [REG_AW-1:0]   Rs2_E,
  output logic                RegWrite_E,
  output logic [RESSRC_W-1:0] ResultSrc_E,
  output logic                MemWrite_E,
  output logic [ALUCTL_W-1:0] ALUControl_E,
  output logic                ALUSrc_E,
  output logic                Branch_E,
  output logic                Jump_E,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  de_payload_t d_pl;
  de_payload_t e_pl;
  de_ctrl_t    e_ctrl;

  // Pack decode-side fields.
  always_comb begin
    d_pl                  = '0;
    d_pl.ctrl.reg_write   = RegWrite_D;
    d_pl.ctrl.result_src  = DE_RESSRC_W'(ResultSrc_D);
    d_pl.ctrl.mem_write   = MemWrite_D;
    d_pl.ctrl.alu_control = DE_ALUCTL_W'(ALUControl_D);
    d_pl.ctrl.alu_src     = ALUSrc_D;
    d_pl.ctrl.branch      = Branch_D;
    d_pl.ctrl.jump        = Jump_D;
    d_pl.data.rd1         = DE_XLEN'(RD1_D);
    d_pl.data.rd2         = DE_XLEN'(RD2_D);
    d_pl.data.pc          = DE_XLEN'(PC_D);
    d_pl.data.imm_ext     = DE_XLEN'(ImmExt_D);
    d_pl.data.rd          = DE_REG_AW'(Rd_D);
    d_pl.data.rs1         = DE_REG_AW'(Rs1_D);
    d_pl.data.rs2         = DE_REG_AW'(Rs2_D);
  end

  pipe_skid_buf #(
    .W    (DE_PAYLOAD_W),
    .SKID (SKID)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (d_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (e_pl)
  );

  // Unpack execute-side fields; data holds its last value while invalid.
  assign e_ctrl       = gate_ctrl(e_pl.ctrl, out_valid);
  assign RegWrite_E   = e_ctrl.reg_write;
  assign ResultSrc_E  = RESSRC_W'(e_ctrl.result_src);
  assign MemWrite_E   = e_ctrl.mem_write;
  assign ALUControl_E = ALUCTL_W'(e_ctrl.alu_control);
  assign ALUSrc_E     = e_ctrl.alu_src;
  assign Branch_E     = e_ctrl.branch;
  assign Jump_E       = e_ctrl.jump;
  assign RD1_E        = XLEN'(e_pl.data.rd1);
  assign RD2_E        = XLEN'(e_pl.data.rd2);
  assign PC_E         = XLEN'(e_pl.data.pc);
  assign ImmExt_E     = XLEN'(e_pl.data.imm_ext);
  assign Rd_E         = REG_AW'(e_pl.data.rd);
  assign Rs1_E        = REG_AW'(e_pl.data.rs1);
  assign Rs2_E        = REG_AW'(e_pl.data.rs2);

  // Saturating perf counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (!out_valid && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Bench for id_ex_elastic_reg: three instances (SKID=1/CNT_W=32, SKID=0/CNT_W=32,
// SKID=1/CNT_W=4) share the decode-side stimulus; each has its own out_ready.
// Expected behaviour comes from a per-instance queue model: capacity 2 (or 1 plus
// pass-through), flush empties it, counters are plain saturating tallies.
module tb_id_ex_elastic_reg;
  import de_pkg::*;

  localparam int N = 3;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  de_payload_t pl_in;

  logic        in_ready   [N];
  logic        out_valid  [N];
  logic        out_ready  [N];
  logic [63:0] rd1_e      [N];
  logic [63:0] rd2_e      [N];
  logic [63:0] pc_e       [N];
  logic [63:0] imm_e      [N];
  logic [4:0]  rd_e       [N];
  logic [4:0]  rs1_e      [N];
  logic [4:0]  rs2_e      [N];
  logic        regw_e     [N];
  logic [1:0]  ressrc_e   [N];
  logic        memw_e     [N];
  logic [3:0]  aluc_e     [N];
  logic        alusrc_e   [N];
  logic        br_e       [N];
  logic        jmp_e      [N];
  logic [31:0] stall_cnt  [N];
  logic [31:0] bubble_cnt [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam bit          SK = (g == 1) ? 1'b0 : 1'b1;
    localparam int unsigned CW = (g == 2) ? 4 : 32;
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;
    id_ex_elastic_reg #(
      .XLEN(64), .REG_AW(5), .ALUCTL_W(4), .RESSRC_W(2), .SKID(SK), .CNT_W(CW)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready[g]),
      .RD1_D        (pl_in.data.rd1),
      .RD2_D        (pl_in.data.rd2),
      .PC_D         (pl_in.data.pc),
      .ImmExt_D     (pl_in.data.imm_ext),
      .Rd_D         (pl_in.data.rd),
      .Rs1_D        (pl_in.data.rs1),
      .Rs2_D        (pl_in.data.rs2),
      .RegWrite_D   (pl_in.ctrl.reg_write),
      .ResultSrc_D  (pl_in.ctrl.result_src),
      .MemWrite_D   (pl_in.ctrl.mem_write),
      .ALUControl_D (pl_in.ctrl.alu_control),
      .ALUSrc_D     (pl_in.ctrl.alu_src),
      .Branch_D     (pl_in.ctrl.branch),
      .Jump_D       (pl_in.ctrl.jump),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready[g]),
      .RD1_E        (rd1_e[g]),
      .RD2_E        (rd2_e[g]),
      .PC_E         (pc_e[g]),
      .ImmExt_E     (imm_e[g]),
      .Rd_E         (rd_e[g]),
      .Rs1_E        (rs1_e[g]),
      .Rs2_E        (rs2_e[g]),
      .RegWrite_E   (regw_e[g]),
      .ResultSrc_E  (ressrc_e[g]),
      .MemWrite_E   (memw_e[g]),
      .ALUControl_E (aluc_e[g]),
      .ALUSrc_E     (alusrc_e[g]),
      .Branch_E     (br_e[g]),
      .Jump_E       (jmp_e[g]),
      .stall_cnt    (sc),
      .bubble_cnt   (bc)
    );
    assign stall_cnt[g]  = 32'(sc);
    assign bubble_cnt[g] = 32'(bc);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  de_payload_t exp_q   [N][$];
  logic        exp_rdy [N];
  logic [31:0] m_stall [N];
  logic [31:0] m_bubble[N];

  task automatic chk(input string name, input int i, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h", name, i, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_max(input int i);
    return (i == 2) ? 32'd15 : 32'hFFFF_FFFF;
  endfunction

  function automatic de_payload_t act_pl(input int i);
    de_payload_t p;
    p.ctrl.reg_write   = regw_e[i];
    p.ctrl.result_src  = ressrc_e[i];
    p.ctrl.mem_write   = memw_e[i];
    p.ctrl.alu_control = aluc_e[i];
    p.ctrl.alu_src     = alusrc_e[i];
    p.ctrl.branch      = br_e[i];
    p.ctrl.jump        = jmp_e[i];
    p.data.rd1         = rd1_e[i];
    p.data.rd2         = rd2_e[i];
    p.data.pc          = pc_e[i];
    p.data.imm_ext     = imm_e[i];
    p.data.rd          = rd_e[i];
    p.data.rs1         = rs1_e[i];
    p.data.rs2         = rs2_e[i];
    return p;
  endfunction

  function automatic de_payload_t rand_pl(input logic [63:0] pc);
    de_payload_t p;
    logic [31:0] r;
    r              = $urandom;
    p.ctrl         = r[$bits(de_ctrl_t)-1:0];
    p.data.rd1     = {$urandom, $urandom};
    p.data.rd2     = {$urandom, $urandom};
    p.data.imm_ext = {$urandom, $urandom};
    p.data.pc      = pc;
    p.data.rd      = r[15:11];
    p.data.rs1     = r[20:16];
    p.data.rs2     = r[25:21];
    return p;
  endfunction

  // Issue side: an accepted beat becomes an expected output; flush kills everything.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        if (flush) exp_q[i].delete();
        else if (in_valid && exp_rdy[i]) exp_q[i].push_back(pl_in);
      end
    end
  end

  // Monitor: compare the presented output against the model, then retire on emit.
  initial forever begin
    int n;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        exp_q[i].delete();
        m_stall[i]  = '0;
        m_bubble[i] = '0;
        exp_rdy[i]  = 1'b0;
      end else begin
        n = exp_q[i].size();
        exp_rdy[i] = (i == 1) ? ((n == 0) || out_ready[i]) : (n < 2);
        chk("in_ready", i, 512'(in_ready[i]), 512'(exp_rdy[i]));
        chk("out_valid", i, 512'(out_valid[i]), 512'(n > 0));
        if (n > 0) chk("payload", i, 512'(act_pl(i)), 512'(exp_q[i][0]));
        else chk("gated_ctrl", i, 512'({regw_e[i], memw_e[i], br_e[i], jmp_e[i]}), 512'(0));
        chk("stall_cnt", i, 512'(stall_cnt[i]), 512'(m_stall[i]));
        chk("bubble_cnt", i, 512'(bubble_cnt[i]), 512'(m_bubble[i]));
        if (n > 0 && out_ready[i]) void'(exp_q[i].pop_front());
        if (n > 0 && !out_ready[i] && m_stall[i] != cnt_max(i)) m_stall[i]++;
        if (n == 0 && m_bubble[i] != cnt_max(i)) m_bubble[i]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic r0, input logic r1, input logic r2);
    out_ready[0] = r0;
    out_ready[1] = r1;
    out_ready[2] = r2;
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < N; i++) begin
      chk("rst_out_valid", i, 512'(out_valid[i]), 512'(0));
      chk("rst_in_ready", i, 512'(in_ready[i]), 512'(1));
      chk("rst_payload", i, 512'(act_pl(i)), 512'(0));
      chk("rst_stall_cnt", i, 512'(stall_cnt[i]), 512'(0));
      chk("rst_bubble_cnt", i, 512'(bubble_cnt[i]), 512'(0));
    end
  endtask

  initial begin
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    pl_in    = '0;
    set_rdy(1'b1, 1'b1, 1'b1);
    step();
    check_reset_state();
    step();
    rst = 1'b1;
    step();

    // Back-to-back stream of PCs 0x0..0x1C with the consumer always ready.
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      pl_in    = rand_pl(64'(k * 4));
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Three-cycle stall in the middle of a stream.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      pl_in    = rand_pl(64'h100 + 64'(k * 4));
      if (k >= 3 && k <= 5) set_rdy(1'b0, 1'b0, 1'b0);
      else set_rdy(1'b1, 1'b1, 1'b1);
      step();
    end
    in_valid = 1'b0;
    set_rdy(1'b1, 1'b1, 1'b1);
    repeat (4) step();

    // Fill while stalled, flush with a beat offered, then PC 0x40 must come out next.
    set_rdy(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      pl_in    = rand_pl(64'h200 + 64'(k * 4));
      step();
    end
    flush = 1'b1;
    pl_in = rand_pl(64'h2F0);
    step();
    flush = 1'b0;
    set_rdy(1'b1, 1'b1, 1'b1);
    pl_in = rand_pl(64'h40);
    step();
    in_valid = 1'b0;
    repeat (3) step();

    // Consumer toggling 1010 while the producer streams.
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      pl_in    = rand_pl(64'h300 + 64'(k * 4));
      set_rdy(k % 2 == 0, k % 2 == 0, k % 2 == 0);
      step();
    end
    in_valid = 1'b0;
    set_rdy(1'b1, 1'b1, 1'b1);
    repeat (4) step();

    // Long stall to saturate the 4-bit counter instance.
    set_rdy(1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    pl_in    = rand_pl(64'h400);
    step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("stall_sat", 2, 512'(stall_cnt[2]), 512'(15));
    step();
    chk("stall_sat_hold", 2, 512'(stall_cnt[2]), 512'(15));
    set_rdy(1'b1, 1'b1, 1'b1);
    repeat (3) step();

    // Reset asserted while entries are in flight.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      pl_in    = rand_pl(64'h500 + 64'(k * 4));
      step();
    end
    chk("pre_rst_valid", 0, 512'(out_valid[0]), 512'(1));
    rst = 1'b0;
    #1;
    check_reset_state();
    step();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();

    // Randomised traffic with occasional flushes.
    for (int k = 0; k < 600; k++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      pl_in    = rand_pl({$urandom, $urandom});
      set_rdy($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      step();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    set_rdy(1'b1, 1'b1, 1'b1);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
